// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - default widths and entry layout shared by the EXE->MEM forwarding queue
package exe_pkg;

   localparam int EXE_ADR_W  = 6;
   localparam int EXE_RES_W  = 32;
   localparam int EXE_DATA_W = 200;

   typedef struct packed {
      logic [EXE_ADR_W-1:0] dest;
      logic [EXE_RES_W-1:0] res;
      logic                 fwd_ok;
      logic                 valid;
   } exe_entry_t;

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - youngest-first forwarding matcher over the queue entries
module fwd_match #(
   parameter int DEPTH = 4,
   parameter int ADR_W = 6,
   parameter int RES_W = 32
) (
   input  logic [$clog2(DEPTH)-1:0]   i_rd_ptr,
   input  logic [$clog2(DEPTH+1)-1:0] i_count,
   input  logic [DEPTH-1:0]           i_valid,
   input  logic [DEPTH-1:0]           i_fwd_ok,
   input  logic [DEPTH*ADR_W-1:0]     i_dest,
   input  logic [DEPTH*RES_W-1:0]     i_res,
   input  logic [ADR_W-1:0]           i_adr,
   output logic                       o_hit,
   output logic                       o_stall,
   output logic [RES_W-1:0]           o_data
);

   localparam int PTR_W = $clog2(DEPTH);

   logic             w_match;
   logic             w_ok;
   logic [RES_W-1:0] w_res;
   logic [PTR_W-1:0] w_idx;

   // Walk oldest to youngest from the head; a later match overrides, so the youngest wins.
   always_comb begin
      w_match = 1'b0;
      w_ok    = 1'b0;
      w_res   = '0;
      w_idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = i_rd_ptr + PTR_W'(k);
         if ((k < int'(i_count)) && i_valid[w_idx] && (i_adr != '0) &&
             (i_dest[w_idx*ADR_W +: ADR_W] == i_adr)) begin
            w_match = 1'b1;
            w_ok    = i_fwd_ok[w_idx];
            w_res   = i_res[w_idx*RES_W +: RES_W];
         end
      end
   end

   always_comb begin
      o_hit   = w_match && w_ok;
      o_stall = w_match && !w_ok;
      o_data  = (w_match && w_ok) ? w_res : '0;
   end

endmodule

// File: rtl/exe_fwd_queue.sv
// rtl/exe_fwd_queue.sv - EXE->MEM circular queue with show-ahead head, flush and
// combinational youngest-first operand forwarding on NUM_RP lookup ports
module exe_fwd_queue
   import exe_pkg::*;
#(
   parameter int DATA_W = EXE_DATA_W,
   parameter int DEPTH  = 4,
   parameter int NUM_RP = 2,
   parameter int ADR_W  = EXE_ADR_W,
   parameter int RES_W  = EXE_RES_W
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [DATA_W-1:0]          i_din,
   input  logic [ADR_W-1:0]           i_din_dest,
   input  logic [RES_W-1:0]           i_din_res,
   input  logic                       i_din_fwd_ok,
   input  logic                       i_pop,
   output logic [DATA_W-1:0]          o_dout,
   output logic [ADR_W-1:0]           o_dout_dest,
   output logic                       o_empty,
   output logic                       o_full,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_ovf_err,
   input  logic [NUM_RP*ADR_W-1:0]    i_lkp_adr,
   output logic [NUM_RP-1:0]          o_lkp_hit,
   output logic [NUM_RP-1:0]          o_lkp_stall,
   output logic [NUM_RP*RES_W-1:0]    o_lkp_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [DEPTH-1:0]  r_valid;
   logic [DEPTH-1:0]  r_fwd_ok;
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [ADR_W-1:0]  r_dest [DEPTH];
   logic [RES_W-1:0]  r_res  [DEPTH];
   logic              r_ovf_err;

   logic                   w_empty;
   logic                   w_full;
   logic                   w_pop_ok;
   logic                   w_push_ok;
   logic [DEPTH*ADR_W-1:0] w_dest_flat;
   logic [DEPTH*RES_W-1:0] w_res_flat;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_pop_ok  = i_pop && !w_empty;
   // A pop in the same cycle frees the slot, so a full queue still takes one push per cycle.
   assign w_push_ok = i_push && (!w_full || w_pop_ok);

   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_valid   <= '0;
         r_ovf_err <= 1'b0;
      end else begin
         r_ovf_err <= i_push && !w_push_ok;
         // Pop is applied first so a push into the slot just vacated keeps its valid bit.
         if (w_pop_ok) begin
            r_valid[r_rd_ptr] <= 1'b0;
            r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push_ok) begin
            r_data[r_wr_ptr]   <= i_din;
            r_dest[r_wr_ptr]   <= i_din_dest;
            r_res[r_wr_ptr]    <= i_din_res;
            r_fwd_ok[r_wr_ptr] <= i_din_fwd_ok;
            r_valid[r_wr_ptr]  <= 1'b1;
            r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_dest_flat = '0;
      w_res_flat  = '0;
      for (int d = 0; d < DEPTH; d++) begin
         w_dest_flat[d*ADR_W +: ADR_W] = r_dest[d];
         w_res_flat[d*RES_W +: RES_W]  = r_res[d];
      end
   end

   assign o_empty     = w_empty;
   assign o_full      = w_full;
   assign o_count     = r_count;
   assign o_ovf_err   = r_ovf_err;
   assign o_dout      = w_empty ? '0 : r_data[r_rd_ptr];
   assign o_dout_dest = w_empty ? '0 : r_dest[r_rd_ptr];

   for (genvar p = 0; p < NUM_RP; p++) begin : g_rp
      fwd_match #(
         .DEPTH (DEPTH),
         .ADR_W (ADR_W),
         .RES_W (RES_W)
      ) u_match (
         .i_rd_ptr (r_rd_ptr),
         .i_count  (r_count),
         .i_valid  (r_valid),
         .i_fwd_ok (r_fwd_ok),
         .i_dest   (w_dest_flat),
         .i_res    (w_res_flat),
         .i_adr    (i_lkp_adr[p*ADR_W +: ADR_W]),
         .o_hit    (o_lkp_hit[p]),
         .o_stall  (o_lkp_stall[p]),
         .o_data   (o_lkp_data[p*RES_W +: RES_W])
      );
   end

endmodule

// File: tb/tb_exe_fwd_queue.sv
// tb/tb_exe_fwd_queue.sv - directed self-checking bench for exe_fwd_queue (DEPTH=4/NUM_RP=2 and DEPTH=8/NUM_RP=3)
module tb_exe_fwd_queue;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // instance A: DEPTH=4, NUM_RP=2
   logic         a_reset = 1'b1, a_flush = 1'b0, a_push = 1'b0, a_pop = 1'b0, a_ok = 1'b0;
   logic [199:0] a_din = '0, a_dout;
   logic [5:0]   a_dest = '0, a_dout_dest;
   logic [31:0]  a_res = '0;
   logic         a_empty, a_full, a_ovf;
   logic [2:0]   a_count;
   logic [11:0]  a_lkp_adr = '0;
   logic [1:0]   a_hit, a_stall;
   logic [63:0]  a_data;

   // instance B: DEPTH=8, NUM_RP=3
   logic         b_reset = 1'b1, b_flush = 1'b0, b_push = 1'b0, b_pop = 1'b0, b_ok = 1'b0;
   logic [199:0] b_din = '0, b_dout;
   logic [5:0]   b_dest = '0, b_dout_dest;
   logic [31:0]  b_res = '0;
   logic         b_empty, b_full, b_ovf;
   logic [3:0]   b_count;
   logic [17:0]  b_lkp_adr = '0;
   logic [2:0]   b_hit, b_stall;
   logic [95:0]  b_data;

   logic [199:0] exp_q[$];

   exe_fwd_queue #(.DATA_W(200), .DEPTH(4), .NUM_RP(2), .ADR_W(6), .RES_W(32)) u_dut_a (
      .i_clk(clk), .i_reset(a_reset), .i_flush(a_flush), .i_push(a_push), .i_din(a_din),
      .i_din_dest(a_dest), .i_din_res(a_res), .i_din_fwd_ok(a_ok), .i_pop(a_pop),
      .o_dout(a_dout), .o_dout_dest(a_dout_dest), .o_empty(a_empty), .o_full(a_full),
      .o_count(a_count), .o_ovf_err(a_ovf), .i_lkp_adr(a_lkp_adr), .o_lkp_hit(a_hit),
      .o_lkp_stall(a_stall), .o_lkp_data(a_data));

   exe_fwd_queue #(.DATA_W(200), .DEPTH(8), .NUM_RP(3), .ADR_W(6), .RES_W(32)) u_dut_b (
      .i_clk(clk), .i_reset(b_reset), .i_flush(b_flush), .i_push(b_push), .i_din(b_din),
      .i_din_dest(b_dest), .i_din_res(b_res), .i_din_fwd_ok(b_ok), .i_pop(b_pop),
      .o_dout(b_dout), .o_dout_dest(b_dout_dest), .o_empty(b_empty), .o_full(b_full),
      .o_count(b_count), .o_ovf_err(b_ovf), .i_lkp_adr(b_lkp_adr), .o_lkp_hit(b_hit),
      .o_lkp_stall(b_stall), .o_lkp_data(b_data));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [15:0] pl, input logic [5:0] dest, input logic [31:0] res, input logic ok);
      a_push = 1'b1; a_din = 200'(pl); a_dest = dest; a_res = res; a_ok = ok;
      tick();
      a_push = 1'b0;
   endtask

   task automatic push_b(input logic [15:0] pl, input logic [5:0] dest, input logic [31:0] res, input logic ok);
      b_push = 1'b1; b_din = 200'(pl); b_dest = dest; b_res = res; b_ok = ok;
      tick();
      b_push = 1'b0;
   endtask

   task automatic test_reset;
      a_reset = 1'b1; b_reset = 1'b1;
      tick();
      a_reset = 1'b0; b_reset = 1'b0;
      a_lkp_adr = {6'd5, 6'd5};
      #1;
      total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", a_empty); end
      total++; if (a_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", a_full); end
      total++; if (a_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", a_count); end
      total++; if (a_dout !== 200'd0 || a_dout_dest !== 6'd0) begin bad++; $display("FAIL reset_dout got=%0h/%0d exp=0/0", a_dout, a_dout_dest); end
      total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", a_ovf); end
      total++; if (a_hit !== 2'b00 || a_stall !== 2'b00 || a_data !== 64'd0) begin bad++; $display("FAIL reset_lkp got=%0b/%0b/%0h exp=0/0/0", a_hit, a_stall, a_data); end
   endtask

   task automatic test_forward;
      push_a(16'h00A1, 6'd5, 32'h11, 1'b1);
      push_a(16'h00B2, 6'd5, 32'h22, 1'b1);
      a_lkp_adr = {6'd0, 6'd5};
      #1;
      total++; if (a_hit !== 2'b01 || a_data[31:0] !== 32'h22) begin bad++; $display("FAIL fwd_youngest got=%0b/%0h exp=01/22", a_hit, a_data[31:0]); end
      total++; if (a_count !== 3'd2 || a_dout !== 200'h00A1 || a_dout_dest !== 6'd5) begin bad++; $display("FAIL fwd_head got=%0d/%0h/%0d exp=2/a1/5", a_count, a_dout, a_dout_dest); end
      a_pop = 1'b1;
      tick();
      total++; if (a_hit[0] !== 1'b1 || a_data[31:0] !== 32'h22 || a_dout !== 200'h00B2) begin bad++; $display("FAIL fwd_pop1 got=%0b/%0h/%0h exp=1/22/b2", a_hit[0], a_data[31:0], a_dout); end
      // the entry being popped must stay visible to the lookup this cycle
      total++; if (a_hit[0] !== 1'b1) begin bad++; $display("FAIL fwd_pop_visible got=%0b exp=1", a_hit[0]); end
      tick();
      a_pop = 1'b0;
      #1;
      total++; if (a_hit !== 2'b00 || a_data !== 64'd0 || a_empty !== 1'b1) begin bad++; $display("FAIL fwd_pop2 got=%0b/%0h/%0b exp=0/0/1", a_hit, a_data, a_empty); end
   endtask

   task automatic test_stall;
      push_a(16'h00C3, 6'd7, 32'h99, 1'b0);
      a_lkp_adr = {6'd0, 6'd7};
      #1;
      total++; if (a_stall !== 2'b01 || a_hit !== 2'b00 || a_data !== 64'd0) begin bad++; $display("FAIL stall_c got=%0b/%0b/%0h exp=01/00/0", a_stall, a_hit, a_data); end
      a_push = 1'b1; a_din = 200'h00D4; a_dest = 6'd7; a_res = 32'h33; a_ok = 1'b1;
      #1;
      total++; if (a_stall[0] !== 1'b1 || a_hit[0] !== 1'b0) begin bad++; $display("FAIL stall_push_same_cycle got=%0b/%0b exp=1/0", a_stall[0], a_hit[0]); end
      tick();
      a_push = 1'b0;
      #1;
      total++; if (a_hit[0] !== 1'b1 || a_stall[0] !== 1'b0 || a_data[31:0] !== 32'h33) begin bad++; $display("FAIL stall_d got=%0b/%0b/%0h exp=1/0/33", a_hit[0], a_stall[0], a_data[31:0]); end
      push_a(16'h00E5, 6'd0, 32'h44, 1'b1);
      a_lkp_adr = {6'd0, 6'd0};
      #1;
      total++; if (a_hit !== 2'b00 || a_stall !== 2'b00 || a_data !== 64'd0) begin bad++; $display("FAIL stall_adr0 got=%0b/%0b/%0h exp=0/0/0", a_hit, a_stall, a_data); end
      a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
   endtask

   task automatic test_full;
      for (int i = 0; i < 4; i++) push_a(16'h00B0 + 16'(i), 6'(1 + i), 32'h101 + 32'(i), 1'b1);
      total++; if (a_full !== 1'b1 || a_count !== 3'd4 || a_empty !== 1'b0) begin bad++; $display("FAIL full_flags got=%0b/%0d/%0b exp=1/4/0", a_full, a_count, a_empty); end
      push_a(16'h00B4, 6'd20, 32'h999, 1'b1);
      total++; if (a_ovf !== 1'b1 || a_count !== 3'd4 || a_dout !== 200'h00B0) begin bad++; $display("FAIL full_ovf got=%0b/%0d/%0h exp=1/4/b0", a_ovf, a_count, a_dout); end
      a_lkp_adr = {6'd0, 6'd20};
      #1;
      total++; if (a_hit[0] !== 1'b0) begin bad++; $display("FAIL full_dropped_lkp got=%0b exp=0", a_hit[0]); end
      a_pop = 1'b1;
      push_a(16'h00C0, 6'd21, 32'h555, 1'b1);
      total++; if (a_ovf !== 1'b0 || a_count !== 3'd4 || a_dout !== 200'h00B1) begin bad++; $display("FAIL full_pushpop got=%0b/%0d/%0h exp=0/4/b1", a_ovf, a_count, a_dout); end
      exp_q.delete();
      exp_q.push_back(200'h00B1); exp_q.push_back(200'h00B2); exp_q.push_back(200'h00B3); exp_q.push_back(200'h00C0);
      for (int i = 0; i < 10; i++) begin
         a_push = 1'b1; a_pop = 1'b1;
         a_din = 200'(16'hD000 + 16'(i)); a_dest = 6'(10 + i); a_res = 32'h300 + 32'(i); a_ok = 1'b1;
         exp_q.push_back(200'(16'hD000 + 16'(i)));
         void'(exp_q.pop_front());
         tick();
         total++; if (a_dout !== exp_q[0] || a_count !== 3'd4) begin bad++; $display("FAIL wrap_%0d got=%0h/%0d exp=%0h/4", i, a_dout, a_count, exp_q[0]); end
      end
      a_push = 1'b0; a_pop = 1'b0;
      a_lkp_adr = {6'd16, 6'd19};
      #1;
      total++; if (a_hit !== 2'b11 || a_data !== {32'h306, 32'h309}) begin bad++; $display("FAIL wrap_lkp got=%0b/%0h exp=11/00000306_00000309", a_hit, a_data); end
      a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
   endtask

   task automatic test_flush;
      for (int i = 0; i < 3; i++) push_a(16'h0F00 + 16'(i), 6'd9, 32'h700 + 32'(i), 1'b1);
      a_flush = 1'b1; a_push = 1'b1; a_din = 200'h0FFF; a_dest = 6'd9;
      tick();
      a_flush = 1'b0; a_push = 1'b0;
      a_lkp_adr = {6'd9, 6'd9};
      #1;
      total++; if (a_empty !== 1'b1 || a_count !== 3'd0 || a_full !== 1'b0) begin bad++; $display("FAIL flush_flags got=%0b/%0d/%0b exp=1/0/0", a_empty, a_count, a_full); end
      total++; if (a_dout !== 200'd0 || a_hit !== 2'b00 || a_stall !== 2'b00) begin bad++; $display("FAIL flush_out got=%0h/%0b/%0b exp=0/0/0", a_dout, a_hit, a_stall); end
   endtask

   task automatic test_push_pop_empty;
      a_pop = 1'b1;
      push_a(16'h00E1, 6'd3, 32'h61, 1'b1);
      a_pop = 1'b0;
      total++; if (a_count !== 3'd1 || a_dout !== 200'h00E1 || a_empty !== 1'b0) begin bad++; $display("FAIL empty_pushpop got=%0d/%0h/%0b exp=1/e1/0", a_count, a_dout, a_empty); end
   endtask

   task automatic test_reset_mid;
      push_a(16'h00E2, 6'd4, 32'h62, 1'b1);
      a_reset = 1'b1; a_push = 1'b1; a_din = 200'h00E3; a_dest = 6'd4;
      tick();
      a_reset = 1'b0; a_push = 1'b0;
      a_lkp_adr = {6'd4, 6'd3};
      #1;
      total++; if (a_empty !== 1'b1 || a_full !== 1'b0 || a_count !== 3'd0 || a_ovf !== 1'b0) begin bad++; $display("FAIL rstmid_flags got=%0b/%0b/%0d/%0b exp=1/0/0/0", a_empty, a_full, a_count, a_ovf); end
      total++; if (a_dout !== 200'd0 || a_dout_dest !== 6'd0 || a_hit !== 2'b00 || a_stall !== 2'b00 || a_data !== 64'd0) begin bad++; $display("FAIL rstmid_out got=%0h/%0d/%0b/%0b/%0h exp=0", a_dout, a_dout_dest, a_hit, a_stall, a_data); end
   endtask

   task automatic test_wide;
      logic [5:0] dests [8];
      dests = '{6'd3, 6'd5, 6'd3, 6'd0, 6'd9, 6'd5, 6'd3, 6'd12};
      for (int i = 0; i < 8; i++) push_b(16'hB800 + 16'(i), dests[i], 32'h200 + 32'(i), (i != 6));
      b_lkp_adr = {6'd0, 6'd5, 6'd3};
      #1;
      total++; if (b_full !== 1'b1 || b_count !== 4'd8) begin bad++; $display("FAIL wide_full got=%0b/%0d exp=1/8", b_full, b_count); end
      total++; if (b_hit !== 3'b010 || b_stall !== 3'b001 || b_data !== {32'h0, 32'h205, 32'h0}) begin bad++; $display("FAIL wide_lkp got=%0b/%0b/%0h exp=010/001/0_205_0", b_hit, b_stall, b_data); end
      b_pop = 1'b1;
      push_b(16'hB808, 6'd3, 32'h2AA, 1'b1);
      b_pop = 1'b0;
      total++; if (b_hit[0] !== 1'b1 || b_stall[0] !== 1'b0 || b_data[31:0] !== 32'h2AA) begin bad++; $display("FAIL wide_wrap_lkp got=%0b/%0b/%0h exp=1/0/2aa", b_hit[0], b_stall[0], b_data[31:0]); end
      total++; if (b_count !== 4'd8 || b_dout !== 200'hB801 || b_dout_dest !== 6'd5) begin bad++; $display("FAIL wide_head got=%0d/%0h/%0d exp=8/b801/5", b_count, b_dout, b_dout_dest); end
      push_b(16'hB809, 6'd1, 32'h2BB, 1'b1);
      total++; if (b_ovf !== 1'b1 || b_count !== 4'd8) begin bad++; $display("FAIL wide_ovf got=%0b/%0d exp=1/8", b_ovf, b_count); end
      b_reset = 1'b1; b_push = 1'b1; b_din = 200'hB80A; b_dest = 6'd3;
      tick();
      b_reset = 1'b0; b_push = 1'b0;
      #1;
      total++; if (b_empty !== 1'b1 || b_full !== 1'b0 || b_count !== 4'd0 || b_ovf !== 1'b0) begin bad++; $display("FAIL wide_rst_flags got=%0b/%0b/%0d/%0b exp=1/0/0/0", b_empty, b_full, b_count, b_ovf); end
      total++; if (b_dout !== 200'd0 || b_dout_dest !== 6'd0 || b_hit !== 3'd0 || b_stall !== 3'd0 || b_data !== 96'd0) begin bad++; $display("FAIL wide_rst_out got=%0h/%0d/%0b/%0b/%0h exp=0", b_dout, b_dout_dest, b_hit, b_stall, b_data); end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_stall();
      test_full();
      test_flush();
      test_push_pop_empty();
      test_reset_mid();
      test_wide();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exe_fwd_queue.md
# exe_fwd_queue

Parametrised, multi-entry EXE→MEM pipeline queue with built-in operand forwarding lookup and flush. It generalises the single-register EXE→MEM buffer in several ways: depth is a parameter, any number of read ports can search every valid entry (youngest wins), and a synchronous flush drops in-flight work on exception or redirect. It sits between the EXE datapath, which pushes, and the MEM stage, which pops, and feeds bypass data back to the EXE operand muxes.

## Interface
- DATA_W, 200: opaque payload width (result, store data, flags, PC, CSR fields).
- DEPTH, 4: number of entries; power of two, ≥2.
- NUM_RP, 2: number of forwarding lookup ports.
- ADR_W, 6: register address width.
- RES_W, 32: forwarded result width.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- FLUSH  in  1  drop all entries at next edge.
- PUSH  in  1  enqueue request.
- DIN  in  DATA_W  payload.
- DIN_DEST  in  ADR_W  destination register of the pushed entry; 0 means no destination.
- DIN_RES  in  RES_W  value to forward.
- DIN_FWD_OK  in  1  1 means DIN_RES is final (0 for load and multiply).
- POP  in  1  dequeue request from MEM.
- DOUT  out  DATA_W  head payload (show-ahead).
- DOUT_DEST  out  ADR_W  head destination.
- EMPTY / FULL  out  1  status.
- COUNT  out  $clog2(DEPTH+1)  occupancy.
- OVF_ERR  out  1  one-cycle pulse when a push is dropped.
- LKP_ADR  in  NUM_RP*ADR_W  lookup addresses, packed with port 0 in the LSBs.
- LKP_HIT  out  NUM_RP  forwardable match found.
- LKP_STALL  out  NUM_RP  youngest match is not forwardable.
- LKP_DATA  out  NUM_RP*RES_W  forwarded value.

## Operation
- Circular buffer with wr_ptr and rd_ptr of width log2(DEPTH); pointers wrap at DEPTH. A count register holds 0..DEPTH.
- Each entry holds payload, dest, res, fwd_ok and a valid bit.
- Update priority: reset > FLUSH > push/pop.
- Reset or FLUSH: pointers, count and all valid bits go to 0. A PUSH or POP in the same cycle is ignored.
- Accepted pop: POP && !EMPTY. An accepted pop clears the head valid bit and advances rd_ptr. POP while empty is ignored.
- Accepted push: PUSH && (!FULL || accepted pop). A push to a full queue is accepted if a pop is accepted in the same cycle; this sustains one transfer per cycle.
- Push while full without a pop: the push is dropped and OVF_ERR pulses.
- Push while empty: the entry is visible on DOUT in the next cycle. There is no same-cycle fall-through.
- DOUT and DOUT_DEST are driven to 0 when EMPTY.
- Lookup (combinational, per port p):
  - Scan valid entries from youngest to oldest.
  - Only the youngest entry whose dest == LKP_ADR[p] counts.
  - LKP_ADR[p] == 0 never matches.
  - Matched entry with fwd_ok=1: LKP_HIT=1, LKP_DATA=res.
  - Matched entry with fwd_ok=0: LKP_STALL=1, LKP_HIT=0.
  - No match: all three outputs are 0.
- The lookup observes current state only. An entry pushed this cycle is not visible until the next cycle; an entry popped this cycle is still visible this cycle.

## Timing
- Reset values: EMPTY=1, FULL=0, COUNT=0, DOUT=0, DOUT_DEST=0, OVF_ERR=0, LKP_HIT=0, LKP_STALL=0, LKP_DATA=0.
- Push-to-DOUT latency is 1 cycle. Lookup latency is 0 cycles (combinational from LKP_ADR and state).
- FULL = (count==DEPTH) and EMPTY = (count==0), both registered-state derived with no combinational path from PUSH or POP.
- Sustained throughput is 1 push and 1 pop per cycle at any occupancy except empty, where a pop has nothing to take.
- Reset or FLUSH asserted mid-stream takes effect at the next edge. The queue is EMPTY in the following cycle regardless of PUSH.

## Structure
- Shared package exe_pkg holds the default widths (ADR_W, RES_W, DATA_W) and the entry struct typedef (dest, res, fwd_ok, valid).
- The payload layout stays owned by the instantiating stage.
- Sub-module fwd_match, instantiated NUM_RP times: a youngest-first priority matcher over DEPTH entries. It takes rd_ptr and count to order the scan.

## Test plan
- Reset, then push A(dest=5, res=0x11, ok=1), B(dest=5, res=0x22, ok=1). Lookup 5 → HIT=1, DATA=0x22. Pop one → DATA=0x22. Pop again → no hit, EMPTY=1.
- Push C(dest=7, ok=0), then lookup 7 → STALL=1, HIT=0. Push D(dest=7, res=0x33, ok=1) → HIT=1, DATA=0x33, STALL=0. Lookup 0 with an entry dest=0 present → no hit.
- With DEPTH=4, fill 4 entries → FULL=1, COUNT=4. Push alone → OVF_ERR pulses and COUNT stays 4. Push and pop together → COUNT stays 4 and the new entry lands at the tail. Run 10 cycles of push+pop to exercise pointer wrap and in-order DOUT.
- Fill 3 entries, then assert FLUSH together with PUSH → next cycle EMPTY=1, COUNT=0, all lookups miss, DOUT=0.
- On an empty queue, PUSH+POP in the same cycle → pop ignored. Next cycle COUNT=1 and DOUT holds the pushed payload.
- Assert reset with 2 entries present and PUSH high → next cycle every output is at its reset value. Repeat with NUM_RP=3 and DEPTH=8 parameters.
